// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and helpers for the instruction fetch stage.
// Imported by inst_fetch and its PC sub-module.
package inst_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 64;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  localparam inst_t      ZeroDoubleWord = '0;
  localparam inst_addr_t ZeroWord       = '0;
  localparam inst_addr_t PcStep         = inst_addr_t'(8);
  localparam logic       ChipEnable     = 1'b1;
  localparam logic       ChipDisable    = 1'b0;
  localparam logic       RstEnable      = 1'b1;

  // What the IF/ID register does on the coming edge.
  typedef enum logic [1:0] {
    IF_HOLD,
    IF_CLEAR,
    IF_REDIR,
    IF_SEQ
  } if_act_e;

  function automatic inst_addr_t align8(inst_addr_t a);
    return a & ~inst_addr_t'(7);
  endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// PC register, ROM chip-enable and pending-branch capture.
// Also decodes the per-edge action used by the IF/ID register.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
  input  logic                   branch_flag,
  input  logic [InstAddrBus-1:0] branch_target,
  output logic                   ce,
  output logic [InstAddrBus-1:0] pc,
  output if_act_e                act
);

  localparam inst_addr_t StartPc = align8(RESET_PC);

  logic       pend_valid;
  inst_addr_t pend_target;

  always_comb begin
    act = IF_SEQ;
    if (ce == ChipDisable)
      act = IF_CLEAR;
    else if (flush)
      act = IF_CLEAR;
    else if (stall)
      act = IF_HOLD;
    else if (pend_valid || branch_flag)
      act = IF_REDIR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      ce          <= ChipDisable;
      pc          <= StartPc;
      pend_valid  <= 1'b0;
      pend_target <= ZeroWord;
    end else if (ce == ChipDisable) begin
      ce <= ChipEnable;
    end else begin
      unique case (act)
        IF_CLEAR: begin
          pc         <= align8(flush_pc);
          pend_valid <= 1'b0;
        end
        // A later branch in the same stall overwrites the earlier one.
        IF_HOLD: begin
          if (branch_flag) begin
            pend_valid  <= 1'b1;
            pend_target <= align8(branch_target);
          end
        end
        IF_REDIR: begin
          pc         <= pend_valid ? pend_target
                                   : align8(branch_target);
          pend_valid <= 1'b0;
        end
        IF_SEQ: pc <= pc + PcStep;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the zero-latency ROM
// and holds the IF/ID pipeline register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [InstAddrBus-1:0] flush_pc,
  input  logic                   branch_flag,
  input  logic [InstAddrBus-1:0] branch_target,
  output logic                   rom_ce,
  output logic [InstAddrBus-1:0] rom_addr,
  input  logic [InstBus-1:0]     rom_inst,
  output logic [InstAddrBus-1:0] id_pc,
  output logic [InstBus-1:0]     id_inst,
  output logic                   id_valid
);

  if_act_e    act;
  inst_addr_t pc;

  inst_fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .ce           (rom_ce),
    .pc           (pc),
    .act          (act)
  );

  assign rom_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      id_pc    <= ZeroWord;
      id_inst  <= ZeroDoubleWord;
      id_valid <= 1'b0;
    end else begin
      unique case (act)
        IF_CLEAR, IF_REDIR: begin
          id_pc    <= ZeroWord;
          id_inst  <= ZeroDoubleWord;
          id_valid <= 1'b0;
        end
        IF_SEQ: begin
          id_pc    <= pc;
          id_inst  <= rom_inst;
          id_valid <= 1'b1;
        end
        default: id_valid <= id_valid;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_flag;
  logic [31:0] flush_pc, branch_target;
  logic        rom_ce, id_valid;
  logic [31:0] rom_addr, id_pc;
  logic [63:0] rom_inst, id_inst;

  logic        w_rst;
  logic        w_zero = 1'b0;
  logic [31:0] w_zero32 = 32'h0;
  logic        w_ce, w_valid;
  logic [31:0] w_addr, w_pc;
  logic [63:0] w_rom, w_inst;

  int checks = 0;
  int errors = 0;

  logic        m_ce, m_pv, m_valid;
  logic [31:0] m_pc, m_pt, m_idpc;
  logic [63:0] m_inst;

  always #5 clk = ~clk;

  assign rom_inst = 64'h1000 + 64'(rom_addr >> 3);
  assign w_rom    = 64'h1000 + 64'(w_addr >> 3);

  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .flush_pc(flush_pc), .branch_flag(branch_flag),
    .branch_target(branch_target), .rom_ce(rom_ce),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .id_pc(id_pc),
    .id_inst(id_inst), .id_valid(id_valid)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(w_rst), .stall(w_zero), .flush(w_zero),
    .flush_pc(w_zero32), .branch_flag(w_zero),
    .branch_target(w_zero32), .rom_ce(w_ce),
    .rom_addr(w_addr), .rom_inst(w_rom), .id_pc(w_pc),
    .id_inst(w_inst), .id_valid(w_valid)
  );

  task automatic model_reset();
    m_ce = 0; m_pv = 0; m_pt = 0; m_pc = 0;
    m_idpc = 0; m_inst = 0; m_valid = 0;
  endtask

  // Behavioural next-state from the fetch rules, using current inputs.
  task automatic model_edge();
    if (!m_ce) begin
      m_ce = 1;
    end else if (flush) begin
      m_pc = flush_pc & ~32'h7; m_pv = 0;
      m_idpc = 0; m_inst = 0; m_valid = 0;
    end else if (stall) begin
      if (branch_flag) begin
        m_pv = 1; m_pt = branch_target & ~32'h7;
      end
    end else if (m_pv || branch_flag) begin
      m_pc = m_pv ? m_pt : (branch_target & ~32'h7);
      m_pv = 0; m_idpc = 0; m_inst = 0; m_valid = 0;
    end else begin
      m_idpc = m_pc; m_inst = 64'h1000 + 64'(m_pc >> 3);
      m_valid = 1; m_pc = m_pc + 32'd8;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_flag = 0;
    flush_pc = 0; branch_target = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_reset();
    #1;
    checks++;
    if ({rom_ce, rom_addr} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_rom got %b/%h exp 0/0", rom_ce, rom_addr);
    end
    checks++;
    if ({id_valid, id_pc, id_inst} !== 97'h0) begin
      errors++;
      $display("FAIL reset_id got %b/%h/%h exp 0/0/0",
               id_valid, id_pc, id_inst);
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_sequential();
    step();
    checks++;
    if ({rom_ce, rom_addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL seq_ce got %b/%h/%b exp 1/0/0",
               rom_ce, rom_addr, id_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({id_valid, id_pc, id_inst} !==
          {1'b1, 32'(i * 8), 64'h1000 + 64'(i)}) begin
        errors++;
        $display("FAIL seq_fetch%0d got %b/%h/%h exp 1/%h/%h", i,
                 id_valid, id_pc, id_inst, i * 8, 64'h1000 + i);
      end
    end
  endtask

  task automatic test_stall();
    test_reset();
    step(); step(); step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({rom_addr, id_pc, id_inst, id_valid} !==
          {32'h10, 32'h8, 64'h1001, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold%0d got %h/%h/%h/%b exp 10/8/1001/1",
                 i, rom_addr, id_pc, id_inst, id_valid);
      end
    end
    stall = 0;
    step();
    checks++;
    if ({id_pc, id_inst} !== {32'h10, 64'h1002}) begin
      errors++;
      $display("FAIL stall_release got %h/%h exp 10/1002",
               id_pc, id_inst);
    end
  endtask

  task automatic test_branch();
    step();
    checks++;
    if (rom_addr !== 32'h20) begin
      errors++;
      $display("FAIL br_setup got %h exp 20", rom_addr);
    end
    branch_flag = 1; branch_target = 32'h45;
    step();
    idle_inputs();
    checks++;
    if ({id_valid, id_inst, rom_addr} !== {1'b0, 64'h0, 32'h40}) begin
      errors++;
      $display("FAIL br_bubble got %b/%h/%h exp 0/0/40",
               id_valid, id_inst, rom_addr);
    end
    step();
    checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h40, 64'h1008}) begin
      errors++;
      $display("FAIL br_fetch got %b/%h/%h exp 1/40/1008",
               id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_pending_branch();
    stall = 1; branch_flag = 1; branch_target = 32'h80;
    step();
    branch_flag = 0;
    step();
    checks++;
    if (rom_addr !== 32'h48) begin
      errors++;
      $display("FAIL pend_hold got %h exp 48", rom_addr);
    end
    stall = 0;
    step();
    checks++;
    if ({rom_addr, id_valid} !== {32'h80, 1'b0}) begin
      errors++;
      $display("FAIL pend_redir got %h/%b exp 80/0", rom_addr, id_valid);
    end
    step();
    checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h80, 64'h1010}) begin
      errors++;
      $display("FAIL pend_fetch got %b/%h/%h exp 1/80/1010",
               id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_flush();
    stall = 1; branch_flag = 1; branch_target = 32'h300;
    flush = 1; flush_pc = 32'h204;
    step();
    idle_inputs();
    checks++;
    if ({rom_addr, id_valid, id_inst} !== {32'h200, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL flush_out got %h/%b/%h exp 200/0/0",
               rom_addr, id_valid, id_inst);
    end
    step();
    checks++;
    if ({id_valid, id_pc, rom_addr} !== {1'b1, 32'h200, 32'h208}) begin
      errors++;
      $display("FAIL flush_nopend got %b/%h/%h exp 1/200/208",
               id_valid, id_pc, rom_addr);
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      branch_flag   = ($urandom_range(0, 5) == 0);
      branch_target = $urandom;
      flush_pc      = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1;
        model_reset();
        #2;
        checks++;
        if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !== 130'h0) begin
          errors++;
          $display("FAIL rnd_async_rst got %b/%h/%h/%h/%b exp zeros",
                   rom_ce, rom_addr, id_pc, id_inst, id_valid);
        end
        rst = 0;
      end
      step();
      checks++;
      if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !==
          {m_ce, m_pc, m_idpc, m_inst, m_valid}) begin
        errors++;
        $display("FAIL rnd%0d got %b/%h/%h/%h/%b exp %b/%h/%h/%h/%b",
                 n, rom_ce, rom_addr, id_pc, id_inst, id_valid,
                 m_ce, m_pc, m_idpc, m_inst, m_valid);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    w_rst = 1;
    #1;
    checks++;
    if ({w_ce, w_addr} !== {1'b0, 32'hFFFF_FFF8}) begin
      errors++;
      $display("FAIL wrap_reset got %b/%h exp 0/fffffff8", w_ce, w_addr);
    end
    @(posedge clk); #1;
    w_rst = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({w_valid, w_pc, w_inst, w_addr} !==
        {1'b1, 32'hFFFF_FFF8, 64'h2000_0FFF, 32'h0}) begin
      errors++;
      $display("FAIL wrap_fetch0 got %b/%h/%h/%h exp 1/fffffff8/20000fff/0",
               w_valid, w_pc, w_inst, w_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({w_valid, w_pc, w_inst} !== {1'b1, 32'h0, 64'h1000}) begin
      errors++;
      $display("FAIL wrap_fetch1 got %b/%h/%h exp 1/0/1000",
               w_valid, w_pc, w_inst);
    end
    #2;
    w_rst = 1;
    #1;
    checks++;
    if ({w_ce, w_addr, w_pc, w_inst, w_valid} !==
        {1'b0, 32'hFFFF_FFF8, 32'h0, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_async_rst got %b/%h/%h/%h/%b exp reset values",
               w_ce, w_addr, w_pc, w_inst, w_valid);
    end
  endtask

  initial begin
    w_rst = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_pending_branch();
    test_flush();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
